// File: rtl/ext_mem_if.sv
// ext_mem_if: word bus between the cache miss controller (initiator) and
// the external memory responder.
//   addr     byte address from the initiator (addr[1:0] ignored by memory)
//   data_in  write data from the initiator
//   re       read strobe, held high across a streaming burst
//   wr       write strobe, held high until ack
//   data_out read data from memory, valid only while ack is high
//   ack      one-cycle word acknowledge from memory
//   busy     memory responder is not idle
interface ext_mem_if #(
  parameter int WORD_SIZE = 32
);
  logic [31:0]          addr;
  logic [WORD_SIZE-1:0] data_in;
  logic                 re;
  logic                 wr;
  logic [WORD_SIZE-1:0] data_out;
  logic                 ack;
  logic                 busy;

  modport master (
    output addr, data_in, re, wr,
    input  data_out, ack, busy
  );

  modport slave (
    input  addr, data_in, re, wr,
    output data_out, ack, busy
  );
endinterface

// File: rtl/ext_mem_responder.sv
// ext_mem_responder: word-addressed main-memory model behind the cache.
// Services single-word writes and streaming line-fill reads, inserting
// LATENCY wait cycles before a one-cycle ack per word.
//   clk      clock, rising edge
//   ctr_rst  asynchronous, active-high reset
//   bus      ext_mem_if slave side (addr/data_in/re/wr in, data_out/ack/busy out)
//
// state | meaning
// IDLE  | no request pending
// WAIT  | counting down wait cycles for the captured request
// ACK   | ack high for exactly one cycle, data_out valid for reads
// DONE  | waiting for the strobe to drop or for a new burst address
module ext_mem_responder #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input logic    clk,
  input logic    ctr_rst,
  ext_mem_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [ADDR_BITS-1:0] cap_idx;
  logic [WORD_SIZE-1:0] cap_data;
  logic                 cap_wr;
  logic                 ack;
  logic [WORD_SIZE-1:0] data_out;

  logic [WORD_SIZE-1:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] idx;
  logic                 new_req;
  logic                 cap_strobe;
  logic                 do_access;
  logic                 unused_addr_bits;

  assign idx     = bus.addr[ADDR_BITS+1:2];
  assign new_req = bus.wr | bus.re;
  // The strobe that must stay high is the one belonging to the captured op;
  // the other strobe is ignored until the next capture.
  assign cap_strobe = cap_wr ? bus.wr : bus.re;
  assign do_access  = (state == WAIT) && cap_strobe && (cnt == '0);

  // Upper address bits alias; the byte offset is ignored.
  assign unused_addr_bits = ^{bus.addr[31:ADDR_BITS+2], bus.addr[1:0]};

  // Store has no reset so contents survive ctr_rst.
  always_ff @(posedge clk) begin
    if (do_access && cap_wr) begin
      mem[cap_idx] <= cap_data;
    end
  end

  always_ff @(posedge clk or posedge ctr_rst) begin
    if (ctr_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_wr   <= 1'b0;
      ack      <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (new_req) begin
            cap_idx  <= idx;
            cap_data <= bus.data_in;
            cap_wr   <= bus.wr;
            cnt      <= CW'(LATENCY);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (!cap_strobe) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            ack      <= 1'b1;
            data_out <= cap_wr ? '0 : mem[cap_idx];
            state    <= ACK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ACK: begin
          ack      <= 1'b0;
          data_out <= '0;
          state    <= DONE;
        end
        DONE: begin
          if (!cap_strobe) begin
            state <= IDLE;
          end else if (idx != cap_idx) begin
            // Streaming path: next burst word captured without an IDLE visit.
            cap_idx  <= idx;
            cap_data <= bus.data_in;
            cap_wr   <= bus.wr;
            cnt      <= CW'(LATENCY);
            state    <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack      = ack;
  assign bus.data_out = data_out;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_ext_mem_responder.sv
// Self-checking bench for ext_mem_responder with a randomized phase checked
// against an array-based memory model.
module tb_ext_mem_responder;
  localparam int WS  = 32;
  localparam int AB  = 10;
  localparam int LAT = 2;
  localparam int DEP = 1 << AB;

  logic clk = 1'b0;
  logic ctr_rst;

  ext_mem_if #(.WORD_SIZE(WS)) bus();

  ext_mem_responder #(.WORD_SIZE(WS), .ADDR_BITS(AB), .LATENCY(LAT)) dut (
    .clk     (clk),
    .ctr_rst (ctr_rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WS-1:0] ref_mem [DEP];
  bit            ref_ok  [DEP];
  int            idx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEP);
  endfunction

  // Counts edges until ack is seen; data_out must be 0 whenever ack is low.
  task automatic wait_ack(input bit want_busy, output int n, output bit seen);
    n = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.ack) seen = 1;
      else chk("dout_zero", bus.data_out, 0);
      if (want_busy) chk("stream_busy", bus.busy, 1);
    end
    if (!seen) chk("ack_timeout", 0, 1);
  endtask

  task automatic xfer(input bit w, input bit r, input logic [31:0] a, input logic [WS-1:0] d);
    int n;
    bit seen;
    int i;
    logic [WS-1:0] exp;
    @(negedge clk);
    bus.addr = a; bus.data_in = d; bus.wr = w; bus.re = r;
    wait_ack(1'b0, n, seen);
    i = word_of(a);
    if (w) begin
      exp = '0;
      ref_mem[i] = d;
      if (!ref_ok[i]) begin
        ref_ok[i] = 1;
        idx_q.push_back(i);
      end
    end else begin
      exp = ref_mem[i];
    end
    if (seen) begin
      chk("latency", n, LAT + 2);
      chk(w ? "wr_dout" : "rd_data", bus.data_out, exp);
    end
    bus.wr = 0; bus.re = 0;
    @(posedge clk); #1;
    chk("ack_one_cycle", bus.ack, 0);
    chk("dout_clear", bus.data_out, 0);
    @(posedge clk); #1;
    chk("busy_idle", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    bus.addr = '0; bus.data_in = '0; bus.wr = 0; bus.re = 0;
    ctr_rst = 1;
    repeat (2) @(negedge clk);
    chk("rst_ack", bus.ack, 0);
    chk("rst_dout", bus.data_out, 0);
    chk("rst_busy", bus.busy, 0);
    ctr_rst = 0;

    // Write then read back.
    xfer(1, 0, 32'h40, 32'hDEADBEEF);
    xfer(0, 1, 32'h40, 32'h0);

    // Streaming read of 16 preloaded words.
    for (int i = 0; i < 16; i++) xfer(1, 0, 32'(4 * i), 32'(32'h100 + i));
    @(negedge clk);
    bus.re = 1; bus.addr = 32'h0;
    for (int i = 0; i < 16; i++) begin
      wait_ack(1'b1, n, seen);
      if (seen) begin
        chk("stream_data", bus.data_out, 32'(32'h100 + i));
        chk("stream_gap", n, (i == 0) ? LAT + 2 : LAT + 3);
      end
      if (i < 15) bus.addr = 32'(4 * (i + 1));
    end
    bus.re = 0;
    repeat (2) @(posedge clk);
    #1 chk("stream_end_idle", bus.busy, 0);

    // Aliasing and write priority.
    xfer(1, 0, 32'h1000, 32'h11);
    xfer(0, 1, 32'h0, 32'h0);
    xfer(1, 1, 32'h80, 32'hCAFE);
    xfer(0, 1, 32'h80, 32'h0);

    // Read aborted in WAIT.
    @(negedge clk); bus.re = 1; bus.addr = 32'h40;
    @(negedge clk); bus.re = 0;
    @(posedge clk); #1;
    chk("abort_rd_busy", bus.busy, 0);
    chk("abort_rd_ack", bus.ack, 0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_rd_noack", bus.ack, 0);
    end

    // Write aborted in WAIT leaves memory unchanged.
    @(negedge clk); bus.wr = 1; bus.addr = 32'h40; bus.data_in = 32'h5555;
    @(negedge clk);
    @(negedge clk); bus.wr = 0;
    @(posedge clk); #1;
    chk("abort_wr_busy", bus.busy, 0);
    chk("abort_wr_ack", bus.ack, 0);
    xfer(0, 1, 32'h40, 32'h0);

    // Async reset during WAIT of a write.
    @(negedge clk); bus.wr = 1; bus.addr = 32'h40; bus.data_in = 32'h7777;
    @(posedge clk); #3;
    ctr_rst = 1;
    #1;
    chk("arst_ack", bus.ack, 0);
    chk("arst_busy", bus.busy, 0);
    @(negedge clk); bus.wr = 0; ctr_rst = 0;
    xfer(0, 1, 32'h40, 32'h0);

    // Randomized writes/reads against the model.
    for (int k = 0; k < 120; k++) begin
      if (idx_q.size() == 0 || $urandom_range(0, 1) == 1) begin
        xfer(1, $urandom_range(0, 3) == 0, $urandom, $urandom);
      end else begin
        int i;
        logic [31:0] a;
        i = idx_q[$urandom_range(0, idx_q.size() - 1)];
        a = ($urandom & ~32'(DEP * 4 - 1)) | 32'(i * 4) | 32'($urandom_range(0, 3));
        xfer(0, 1, a, 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
